// File: rtl/div_pkg.sv
// Shared definitions for the programmable clock divider: output mode
// encoding and the smallest divisor the counter accepts.
package div_pkg;

    typedef enum logic {
        MODE_PULSE  = 1'b0,
        MODE_SQUARE = 1'b1
    } mode_e;

    localparam int DIV_MIN = 2;

endpackage

// File: rtl/div_load_ctrl.sv
// Divisor load path: validates requested divisors, holds them in a shadow
// register and hands the next divisor to the counter at its wrap edge.
module div_load_ctrl
    import div_pkg::*;
#(
    parameter int M         = 10,
    parameter int N_DEFAULT = 1000
) (
    input  logic         i_clk,
    input  logic         i_clear,
    input  logic         i_load,
    input  logic [M-1:0] i_div_in,
    input  logic         i_wrap,
    output logic [M-1:0] o_div,
    output logic [M-1:0] o_div_next,
    output logic         o_pending,
    output logic         o_div_err
);

    logic [M-1:0] r_div;
    logic [M-1:0] r_shadow;
    logic         r_pending;
    logic         r_div_err;
    logic         w_load_ok;
    logic [M-1:0] w_div_next;

    assign w_load_ok = i_load && (i_div_in >= M'(DIV_MIN));

    // A valid load on the wrap edge bypasses the shadow so it takes effect at once.
    always_comb begin
        // NOTE: default first so every path assigns the signal and no latch is inferred.
        w_div_next = r_div;
        if (i_wrap) begin
            if (w_load_ok) begin
                w_div_next = i_div_in;
            end else if (r_pending) begin
                w_div_next = r_shadow;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_clear) begin
        if (i_clear) begin
            r_div     <= M'(N_DEFAULT);
            r_shadow  <= M'(N_DEFAULT);
            r_pending <= 1'b0;
            r_div_err <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            r_div <= w_div_next;
            if (w_load_ok) begin
                r_shadow <= i_div_in;
            end
            if (w_load_ok && !i_wrap) begin
                r_pending <= 1'b1;
            end else if (i_wrap) begin
                r_pending <= 1'b0;
            end
            if (i_load) begin
                r_div_err <= !w_load_ok;
            end
        end
    end

    assign o_div      = r_div;
    assign o_div_next = w_div_next;
    assign o_pending  = r_pending;
    assign o_div_err  = r_div_err;

endmodule

// File: rtl/prog_clock_divider.sv
// Runtime-programmable divide-by-D counter with pulse or near-50% square
// output, terminal-count flag and glitch-free divisor reload at the wrap.
module prog_clock_divider
    import div_pkg::*;
#(
    parameter int M         = 10,
    parameter int N_DEFAULT = 1000
) (
    input  logic         CLK,
    input  logic         CLEAR,
    input  logic         EN,
    input  logic         LOAD,
    input  logic [M-1:0] DIV_IN,
    input  logic         MODE,
    output logic [M-1:0] COUNT,
    output logic         OUT,
    output logic         TC,
    output logic         PENDING,
    output logic         DIV_ERR
);

    logic [M-1:0] r_count;
    logic         r_out;
    logic         r_tc;
    logic [M-1:0] w_div;
    logic [M-1:0] w_div_next;
    logic         w_wrap;
    logic [M-1:0] w_count_next;
    logic         w_out_next;
    mode_e        w_mode;

    assign w_mode = mode_e'(MODE);
    assign w_wrap = EN && (r_count == (w_div - M'(1)));

    div_load_ctrl #(
        .M         (M),
        .N_DEFAULT (N_DEFAULT)
    ) u_load_ctrl (
        .i_clk      (CLK),
        .i_clear    (CLEAR),
        .i_load     (LOAD),
        .i_div_in   (DIV_IN),
        .i_wrap     (w_wrap),
        .o_div      (w_div),
        .o_div_next (w_div_next),
        .o_pending  (PENDING),
        .o_div_err  (DIV_ERR)
    );

    // OUT is decoded from the count and divisor that will hold after this edge.
    always_comb begin
        w_count_next = r_count;
        w_out_next   = 1'b0;
        if (!EN) begin
            w_out_next = (w_mode == MODE_SQUARE) ? r_out : 1'b0;
        end else begin
            w_count_next = w_wrap ? '0 : r_count + M'(1);
            if (w_mode == MODE_PULSE) begin
                w_out_next = (w_count_next == (w_div_next - M'(1)));
            end else begin
                w_out_next = (w_count_next < (w_div_next >> 1));
            end
        end
    end

    always_ff @(posedge CLK or posedge CLEAR) begin
        if (CLEAR) begin
            r_count <= '0;
            r_out   <= 1'b0;
            r_tc    <= 1'b0;
        end else begin
            r_count <= w_count_next;
            r_out   <= w_out_next;
            r_tc    <= w_wrap;
        end
    end

    assign COUNT = r_count;
    assign OUT   = r_out;
    assign TC    = r_tc;

endmodule

// File: tb/tb_prog_clock_divider.sv
// Scoreboard bench for prog_clock_divider (M=4, N_DEFAULT=5): directed
// vectors push hand-computed post-edge outputs, a monitor compares them.
module tb_prog_clock_divider;

    localparam int M  = 4;
    localparam int ND = 5;

    logic         CLK;
    logic         CLEAR;
    logic         EN;
    logic         LOAD;
    logic [M-1:0] DIV_IN;
    logic         MODE;
    logic [M-1:0] COUNT;
    logic         OUT;
    logic         TC;
    logic         PENDING;
    logic         DIV_ERR;

    typedef struct {
        int         row;
        logic [3:0] count;
        logic       out;
        logic       tc;
        logic       pend;
        logic       err;
    } exp_t;

    exp_t q[$];
    exp_t mx;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   row      = 0;

    prog_clock_divider #(
        .M         (M),
        .N_DEFAULT (ND)
    ) dut (
        .CLK     (CLK),
        .CLEAR   (CLEAR),
        .EN      (EN),
        .LOAD    (LOAD),
        .DIV_IN  (DIV_IN),
        .MODE    (MODE),
        .COUNT   (COUNT),
        .OUT     (OUT),
        .TC      (TC),
        .PENDING (PENDING),
        .DIV_ERR (DIV_ERR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, then queue the outputs expected after that edge.
    task automatic step(input logic en, input logic ld, input logic [3:0] dv, input logic md,
                        input int c, input logic o, input logic t, input logic p, input logic e);
        exp_t x;
        EN     = en;
        LOAD   = ld;
        DIV_IN = dv;
        MODE   = md;
        @(posedge CLK);
        row++;
        x.row   = row;
        x.count = 4'(c);
        x.out   = o;
        x.tc    = t;
        x.pend  = p;
        x.err   = e;
        q.push_back(x);
        #1;
        LOAD = 1'b0;
    endtask

    initial begin
        forever begin
            @(negedge CLK);
            if (q.size() > 0) begin
                mx = q.pop_front();
                check($sformatf("count@row%0d", mx.row), 32'(COUNT), 32'(mx.count));
                check($sformatf("out@row%0d", mx.row), 32'(OUT), 32'(mx.out));
                check($sformatf("tc@row%0d", mx.row), 32'(TC), 32'(mx.tc));
                check($sformatf("pending@row%0d", mx.row), 32'(PENDING), 32'(mx.pend));
                check($sformatf("div_err@row%0d", mx.row), 32'(DIV_ERR), 32'(mx.err));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench still running at %0t, expected to be finished", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        CLEAR  = 1'b1;
        EN     = 1'b0;
        LOAD   = 1'b0;
        DIV_IN = '0;
        MODE   = 1'b0;
        #12;
        check("reset_count", 32'(COUNT), 0);
        check("reset_out", 32'(OUT), 0);
        check("reset_tc", 32'(TC), 0);
        check("reset_pending", 32'(PENDING), 0);
        check("reset_div_err", 32'(DIV_ERR), 0);
        @(negedge CLK);
        CLEAR = 1'b0;

        // Pulse mode, default D=5: two full periods.
        for (int k = 1; k <= 10; k++)
            step(1, 0, 0, 0, k % 5, (k % 5) == 4, (k % 5) == 0, 0, 0);

        // Square mode, D=5: OUT 1,1,0,0,0 per period.
        for (int k = 1; k <= 10; k++)
            step(1, 0, 0, 1, k % 5, (k % 5) < 2, (k % 5) == 0, 0, 0);

        // Reload to 2 at COUNT==0; applies at the next wrap, then OUT alternates.
        step(1, 1, 2, 1, 1, 1, 0, 1, 0);
        step(1, 0, 0, 1, 2, 0, 0, 1, 0);
        step(1, 0, 0, 1, 3, 0, 0, 1, 0);
        step(1, 0, 0, 1, 4, 0, 0, 1, 0);
        step(1, 0, 0, 1, 0, 1, 1, 0, 0);
        step(1, 0, 0, 1, 1, 0, 0, 0, 0);
        step(1, 0, 0, 1, 0, 1, 1, 0, 0);
        step(1, 0, 0, 1, 1, 0, 0, 0, 0);
        step(1, 0, 0, 1, 0, 1, 1, 0, 0);

        // Back to D=5 in pulse mode, then load 3 at COUNT==1.
        step(1, 1, 5, 0, 1, 1, 0, 1, 0);
        step(1, 0, 0, 0, 0, 0, 1, 0, 0);
        step(1, 0, 0, 0, 1, 0, 0, 0, 0);
        step(1, 1, 3, 0, 2, 0, 0, 1, 0);
        step(1, 0, 0, 0, 3, 0, 0, 1, 0);
        step(1, 0, 0, 0, 4, 1, 0, 1, 0);
        step(1, 0, 0, 0, 0, 0, 1, 0, 0);
        step(1, 0, 0, 0, 1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 2, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 1, 0, 0);
        step(1, 0, 0, 0, 1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 2, 1, 0, 0, 0);
        // Load 4 exactly on a wrap edge: used immediately, PENDING never rises.
        step(1, 1, 4, 0, 0, 0, 1, 0, 0);
        step(1, 0, 0, 0, 1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 2, 0, 0, 0, 0);
        step(1, 0, 0, 0, 3, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 1, 0, 0);

        // Invalid loads 1 and 0: DIV_ERR set, D=4 kept; then a valid load of 7.
        step(1, 1, 1, 0, 1, 0, 0, 0, 1);
        step(1, 1, 0, 0, 2, 0, 0, 0, 1);
        step(1, 0, 0, 0, 3, 1, 0, 0, 1);
        step(1, 0, 0, 0, 0, 0, 1, 0, 1);
        step(1, 1, 7, 0, 1, 0, 0, 1, 0);
        step(1, 0, 0, 0, 2, 0, 0, 1, 0);
        step(1, 0, 0, 0, 3, 1, 0, 1, 0);
        step(1, 0, 0, 0, 0, 0, 1, 0, 0);
        for (int k = 1; k <= 7; k++)
            step(1, 0, 0, 0, k % 7, (k % 7) == 6, (k % 7) == 0, 0, 0);
        // Pending 5, then an invalid load on the wrap edge: 5 still applies.
        step(1, 1, 5, 0, 1, 0, 0, 1, 0);
        for (int k = 2; k <= 5; k++)
            step(1, 0, 0, 0, k, 0, 0, 1, 0);
        step(1, 0, 0, 0, 6, 1, 0, 1, 0);
        step(1, 1, 0, 0, 0, 0, 1, 0, 1);
        for (int k = 1; k <= 5; k++)
            step(1, 0, 0, 0, k % 5, (k % 5) == 4, (k % 5) == 0, 0, 1);

        // EN low at COUNT==2: count holds, TC and pulse OUT low.
        step(1, 0, 0, 0, 1, 0, 0, 0, 1);
        step(1, 0, 0, 0, 2, 0, 0, 0, 1);
        repeat (3) step(0, 0, 0, 0, 2, 0, 0, 0, 1);
        step(1, 0, 0, 0, 3, 0, 0, 0, 1);
        step(1, 0, 0, 0, 4, 1, 0, 0, 1);
        step(1, 0, 0, 0, 0, 0, 1, 0, 1);
        // Square mode with EN low: OUT holds its high level.
        step(1, 0, 0, 1, 1, 1, 0, 0, 1);
        repeat (2) step(0, 0, 0, 1, 1, 1, 0, 0, 1);
        step(1, 0, 0, 1, 2, 0, 0, 0, 1);
        step(1, 0, 0, 1, 3, 0, 0, 0, 1);
        step(1, 0, 0, 1, 4, 0, 0, 0, 1);
        step(1, 0, 0, 1, 0, 1, 1, 0, 1);

        // Largest legal divisor, 2^M-1 = 15.
        step(1, 1, 15, 0, 1, 0, 0, 1, 0);
        step(1, 0, 0, 0, 2, 0, 0, 1, 0);
        step(1, 0, 0, 0, 3, 0, 0, 1, 0);
        step(1, 0, 0, 0, 4, 1, 0, 1, 0);
        step(1, 0, 0, 0, 0, 0, 1, 0, 0);
        for (int k = 1; k <= 15; k++)
            step(1, 0, 0, 0, k % 15, (k % 15) == 14, (k % 15) == 0, 0, 0);

        // Pending 3 plus a rejected load, then an asynchronous mid-cycle CLEAR.
        step(1, 1, 3, 0, 1, 0, 0, 1, 0);
        step(1, 1, 1, 0, 2, 0, 0, 1, 1);
        @(negedge CLK);
        #2;
        CLEAR = 1'b1;
        #1;
        check("clear_async_count", 32'(COUNT), 0);
        check("clear_async_out", 32'(OUT), 0);
        check("clear_async_tc", 32'(TC), 0);
        check("clear_async_pending", 32'(PENDING), 0);
        check("clear_async_div_err", 32'(DIV_ERR), 0);
        @(posedge CLK);
        #2;
        check("clear_held_count", 32'(COUNT), 0);
        CLEAR = 1'b0;
        @(negedge CLK);
        // Divisor back to the default 5, pending 3 discarded.
        for (int k = 1; k <= 7; k++)
            step(1, 0, 0, 0, k % 5, (k % 5) == 4, (k % 5) == 0, 0, 0);

        for (int i = 0; i < 10 && q.size() > 0; i++)
            @(negedge CLK);
        #1;
        check("scoreboard_drained", 32'(q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
